// File: rtl/wb_sdram_pkg.sv
// Shared types and constants for the Wishbone SDRAM read-prefetch stage.
// Contents: the FSM state enum, the line index/tag width helpers, and the
// mask that aligns a byte address down to the start of a prefetch line.
package wb_sdram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR        = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam int LINE_WORDS_DEF = 4;
  localparam int AW_DEF         = 23;

  // Bits needed to select a word inside a line.
  function automatic int idx_w_f(input int line_words);
    return $clog2(line_words);
  endfunction

  // Bits of the byte address above the line offset.
  function automatic int tag_w_f(input int aw, input int line_words);
    return aw - 2 - $clog2(line_words);
  endfunction

  // Clears the word index and byte offset, leaving the line base address.
  function automatic logic [31:0] base_mask_f(input int line_words);
    return ~((32'd1 << (idx_w_f(line_words) + 2)) - 32'd1);
  endfunction

  localparam int          IDX_W     = idx_w_f(LINE_WORDS_DEF);
  localparam int          TAG_W     = tag_w_f(AW_DEF, LINE_WORDS_DEF);
  localparam logic [31:0] BASE_MASK = base_mask_f(LINE_WORDS_DEF);

endpackage

// File: rtl/wb_sdram_prefetch_line_buf.sv
// prefetch_line_buf: LINE_WORDS x 32-bit storage for the buffered line.
// Ports:
//   clk      clock
//   wr_be    per-byte write enables (all ones for a fill, sel for write-through)
//   wr_idx   word written
//   wr_data  write data
//   rd_idx   word read (combinational read)
//   rd_data  read data
module prefetch_line_buf
  import wb_sdram_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                             clk,
  input  logic [3:0]                       wr_be,
  input  logic [idx_w_f(LINE_WORDS)-1:0]   wr_idx,
  input  logic [31:0]                      wr_data,
  input  logic [idx_w_f(LINE_WORDS)-1:0]   rd_idx,
  output logic [31:0]                      rd_data
);

  logic [31:0] mem_r [LINE_WORDS];

  // Byte-granular write of one line word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/wb_sdram_prefetch.sv
// wb_sdram_prefetch: Wishbone read-prefetch / request sequencer in front of
// the SDRAM controller. Writes are forwarded one-for-one (write-through into
// the line on a hit); a read miss fetches a whole aligned line one request
// at a time; reads that hit the line are answered locally.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   wbs_*                      Wishbone slave (single-word transactions)
//   flush                      invalidates the buffered line
//   ctrl_addr/rw/data_in/mask  request to controller, ctrl_in_valid qualifies
//   ctrl_busy                  controller cannot accept this cycle
//   ctrl_data_out/out_valid    read data strobe from controller
module wb_sdram_prefetch
  import wb_sdram_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int AW         = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic          flush,
  output logic [AW-1:0] ctrl_addr,
  output logic          ctrl_rw,
  output logic [31:0]   ctrl_data_in,
  output logic [3:0]    ctrl_mask,
  output logic          ctrl_in_valid,
  input  logic          ctrl_busy,
  input  logic [31:0]   ctrl_data_out,
  input  logic          ctrl_out_valid
);

  localparam int          IW       = idx_w_f(LINE_WORDS);
  localparam int          TW       = tag_w_f(AW, LINE_WORDS);
  localparam logic [31:0] BMASK    = base_mask_f(LINE_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(LINE_WORDS - 1);

  state_t          state_r;
  logic [AW-1:2]   adr_r;          // word address of the sampled request
  logic [AW-1:0]   base_r;         // line base for the fill in progress
  logic [3:0]      sel_r;
  logic [31:0]     wdat_r;
  logic [IW-1:0]   cnt_r;          // word being fetched
  logic            line_valid_r;
  logic            flush_pend_r;   // flush seen while a fill was running
  logic [TW-1:0]   line_tag_r;
  logic            ack_r;
  logic [31:0]     dat_r;

  logic            req_s;
  logic            hit_in_s;
  logic            hit_wr_s;
  logic [AW-1:0]   a_in_s;
  logic [3:0]      buf_be_s;
  logic [IW-1:0]   buf_widx_s;
  logic [31:0]     buf_wdata_s;
  logic [31:0]     buf_rdata_s;
  logic            unused_s;

  assign a_in_s    = wbs_adr_i[AW-1:0];
  assign req_s     = wbs_stb_i & wbs_cyc_i;
  assign hit_in_s  = line_valid_r && (a_in_s[AW-1:AW-TW] == line_tag_r);
  assign hit_wr_s  = line_valid_r && (adr_r[AW-1:AW-TW] == line_tag_r);
  assign unused_s  = ^{wbs_adr_i[31:AW], a_in_s[1:0]};
  assign wbs_ack_o = ack_r;
  assign wbs_dat_o = dat_r;

  prefetch_line_buf #(.LINE_WORDS(LINE_WORDS)) u_buf (
    .clk     (clk),
    .wr_be   (buf_be_s),
    .wr_idx  (buf_widx_s),
    .wr_data (buf_wdata_s),
    .rd_idx  (adr_r[IW+1:2]),
    .rd_data (buf_rdata_s)
  );

  // Line buffer write port: fill words take all bytes, write hits merge sel.
  always_comb begin
    buf_be_s    = 4'b0000;
    buf_widx_s  = cnt_r;
    buf_wdata_s = ctrl_data_out;
    case (state_r)
      FILL_WAIT: begin
        if (ctrl_out_valid) buf_be_s = 4'b1111;
        else                buf_be_s = 4'b0000;
      end
      WR: begin
        buf_widx_s  = adr_r[IW+1:2];
        buf_wdata_s = wdat_r;
        if (!ctrl_busy && hit_wr_s) buf_be_s = sel_r;
        else                        buf_be_s = 4'b0000;
      end
      default: buf_be_s = 4'b0000;
    endcase
  end

  // Controller request decoded from state and latched request fields.
  always_comb begin
    ctrl_in_valid = 1'b0;
    ctrl_rw       = 1'b0;
    ctrl_addr     = {AW{1'b0}};
    ctrl_data_in  = 32'd0;
    ctrl_mask     = 4'b0000;
    case (state_r)
      WR: begin
        ctrl_in_valid = 1'b1;
        ctrl_rw       = 1'b1;
        ctrl_addr     = {adr_r, 2'b00};
        ctrl_data_in  = wdat_r;
        ctrl_mask     = sel_r;
      end
      FILL_REQ: begin
        ctrl_in_valid = 1'b1;
        ctrl_addr     = base_r + AW'({cnt_r, 2'b00});
      end
      default: ctrl_in_valid = 1'b0;
    endcase
  end

  // Main sequencer with registered Wishbone response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      adr_r        <= '0;
      base_r       <= {AW{1'b0}};
      sel_r        <= 4'b0000;
      wdat_r       <= 32'd0;
      cnt_r        <= {IW{1'b0}};
      line_valid_r <= 1'b0;
      flush_pend_r <= 1'b0;
      line_tag_r   <= {TW{1'b0}};
      ack_r        <= 1'b0;
      dat_r        <= 32'd0;
    end else begin
      ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (flush) line_valid_r <= 1'b0;
          // ack_r high means the master has not yet seen the previous ack.
          if (req_s && !ack_r) begin
            adr_r  <= a_in_s[AW-1:2];
            sel_r  <= wbs_sel_i;
            wdat_r <= wbs_dat_i;
            if (wbs_we_i) begin
              state_r <= WR;
            end else if (hit_in_s) begin
              state_r <= RESP;
            end else begin
              line_valid_r <= 1'b0;
              base_r       <= a_in_s & BMASK[AW-1:0];
              cnt_r        <= {IW{1'b0}};
              flush_pend_r <= 1'b0;
              state_r      <= FILL_REQ;
            end
          end
        end
        WR: begin
          if (flush) line_valid_r <= 1'b0;
          if (!ctrl_busy) begin
            ack_r   <= 1'b1;
            state_r <= IDLE;
          end
        end
        FILL_REQ: begin
          if (flush) flush_pend_r <= 1'b1;
          if (!ctrl_busy) state_r <= FILL_WAIT;
        end
        FILL_WAIT: begin
          if (flush) flush_pend_r <= 1'b1;
          if (ctrl_out_valid) begin
            if (cnt_r == LAST_IDX) begin
              // A flush during the fill leaves the completed line invalid.
              line_valid_r <= !(flush_pend_r || flush);
              line_tag_r   <= base_r[AW-1:AW-TW];
              flush_pend_r <= 1'b0;
              state_r      <= RESP;
            end else begin
              cnt_r   <= cnt_r + 1'b1;
              state_r <= FILL_REQ;
            end
          end
        end
        RESP: begin
          if (flush) line_valid_r <= 1'b0;
          // Master may have abandoned the cycle during a long fill.
          ack_r <= req_s;
          if (req_s) dat_r <= buf_rdata_s;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
